// File: rtl/cacheline_adapter_pkg.sv
// cacheline_adapter_pkg
// Shared types, sizes and helpers for the cache-line to burst adapter.
//   cacheline_t      : one full cache line (256 bits)
//   burst_t          : one memory burst beat (64 bits)
//   adapter_state_t  : adapter FSM states
//   beat_select()    : picks one beat out of a line
//   align_address()  : clears the line-offset bits of an address
// No ports; imported by the interface, the top and the beat counter.
package cacheline_adapter_pkg;

  localparam int S_LINE      = 256;
  localparam int S_BURST     = 64;
  localparam int S_OFFSET    = 5;
  localparam int BURST_BEATS = S_LINE / S_BURST;

  typedef logic [S_LINE-1:0]  cacheline_t;
  typedef logic [S_BURST-1:0] burst_t;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_DONE,
    WR,
    WR_DONE
  } adapter_state_t;

  function automatic burst_t beat_select(input cacheline_t line, input logic [1:0] idx);
    return line[int'(idx)*S_BURST +: S_BURST];
  endfunction

  // Masking (rather than slicing) keeps every address bit in use.
  function automatic logic [31:0] align_address(input logic [31:0] addr);
    return addr & ~((32'd1 << S_OFFSET) - 32'd1);
  endfunction

endpackage

// File: rtl/cacheline_adapter_if.sv
// cacheline_adapter_if
// Bundles the cache-side line port and the memory-side burst port.
//   Cache side : line_i, address_i, read_i, write_i (to adapter)
//                line_o, resp_o (from adapter)
//   Memory side: burst_i, resp_i (to adapter)
//                burst_o, address_o, read_o, write_o (from adapter)
// Modports:
//   slave  : the adapter's view
//   master : the surrounding cache + memory environment's view
interface cacheline_adapter_if;
  import cacheline_adapter_pkg::*;

  cacheline_t  line_i;
  cacheline_t  line_o;
  logic [31:0] address_i;
  logic        read_i;
  logic        write_i;
  logic        resp_o;
  burst_t      burst_i;
  burst_t      burst_o;
  logic [31:0] address_o;
  logic        read_o;
  logic        write_o;
  logic        resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );

endinterface

// File: rtl/cacheline_adapter_beat.sv
// adapter_beat_counter
// Two-bit beat index for a 4-beat burst.
//   clk, reset : clock, async active-high reset
//   clear      : restart at beat 0 (new transaction)
//   advance    : step to the next beat (memory acknowledged one)
//   count      : current beat index
//   last       : current beat is the final beat of the line
module adapter_beat_counter
  import cacheline_adapter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       advance,
  output logic [1:0] count,
  output logic       last
);

  // The advance on the final beat wraps naturally back to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 2'd0;
    end else if (clear) begin
      count <= 2'd0;
    end else if (advance) begin
      count <= count + 2'd1;
    end
  end

  assign last = (count == 2'(BURST_BEATS - 1));

endmodule

// File: rtl/cacheline_adapter.sv
// cacheline_adapter
// Turns one 256-bit cache line read/write into a 4-beat 64-bit memory
// burst, and returns one line response after the last beat.
//   clk, reset : clock, async active-high reset
//   bus        : cacheline_adapter_if.slave (cache line port + burst port)
// Optional (macro CACHELINE_ADAPTER_PERF_EN):
//   rd_count_o     : completed line reads, saturating
//   wr_count_o     : completed line writes, saturating
//   stall_cycles_o : burst cycles spent waiting on memory, saturating
module cacheline_adapter
  import cacheline_adapter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  cacheline_adapter_if.slave bus
`ifdef CACHELINE_ADAPTER_PERF_EN
  ,
  output logic [31:0] rd_count_o,
  output logic [31:0] wr_count_o,
  output logic [31:0] stall_cycles_o
`endif
);

  adapter_state_t state, state_next;
  logic           read_q, read_next;
  logic           write_q, write_next;
  logic           resp_q, resp_next;
  logic           count_clear, count_advance;
  logic           accept_read, accept_write, capture_beat;
  logic [1:0]     beat_count;
  logic           last_beat;
  cacheline_t     write_buffer;
  cacheline_t     line_q;
  burst_t         burst_q;
  logic [31:0]    address_q;

  adapter_beat_counter beat_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (count_clear),
    .advance (count_advance),
    .count   (beat_count),
    .last    (last_beat)
  );

  // State and registered control outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      state   <= state_next;
      read_q  <= read_next;
      write_q <= write_next;
      resp_q  <= resp_next;
    end
  end

  // Next-state logic. resp is raised on the same edge that enters a DONE
  // state so it is visible during the single DONE cycle.
  always_comb begin
    state_next    = state;
    read_next     = read_q;
    write_next    = write_q;
    resp_next     = 1'b0;
    count_clear   = 1'b0;
    count_advance = 1'b0;
    accept_read   = 1'b0;
    accept_write  = 1'b0;
    capture_beat  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.read_i) begin
          state_next  = RD;
          read_next   = 1'b1;
          count_clear = 1'b1;
          accept_read = 1'b1;
        end else if (bus.write_i) begin
          state_next   = WR;
          write_next   = 1'b1;
          count_clear  = 1'b1;
          accept_write = 1'b1;
        end
      end
      RD: begin
        if (bus.resp_i) begin
          count_advance = 1'b1;
          capture_beat  = 1'b1;
          if (last_beat) begin
            read_next  = 1'b0;
            resp_next  = 1'b1;
            state_next = RD_DONE;
          end
        end
      end
      WR: begin
        if (bus.resp_i) begin
          count_advance = 1'b1;
          if (last_beat) begin
            write_next = 1'b0;
            resp_next  = 1'b1;
            state_next = WR_DONE;
          end
        end
      end
      RD_DONE, WR_DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        read_next  = 1'b0;
        write_next = 1'b0;
      end
    endcase
  end

  // Datapath: address/write buffer capture, read line assembly, and the
  // write beat presented to memory (pre-loaded with beat 0 on accept,
  // then stepped to the next beat after each acknowledge).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      address_q    <= '0;
      write_buffer <= '0;
      line_q       <= '0;
      burst_q      <= '0;
    end else begin
      if (accept_read || accept_write) begin
        address_q <= align_address(bus.address_i);
      end
      if (accept_write) begin
        write_buffer <= bus.line_i;
        burst_q      <= bus.line_i[S_BURST-1:0];
      end
      if (capture_beat) begin
        line_q[int'(beat_count)*S_BURST +: S_BURST] <= bus.burst_i;
      end
      if (state == WR && bus.resp_i && !last_beat) begin
        burst_q <= beat_select(write_buffer, beat_count + 2'd1);
      end
    end
  end

  assign bus.line_o    = line_q;
  assign bus.resp_o    = resp_q;
  assign bus.burst_o   = burst_q;
  assign bus.address_o = address_q;
  assign bus.read_o    = read_q;
  assign bus.write_o   = write_q;

`ifdef CACHELINE_ADAPTER_PERF_EN
  logic rd_finish, wr_finish, stall_now;

  assign rd_finish = resp_next && (state == RD);
  assign wr_finish = resp_next && (state == WR);
  assign stall_now = ((state == RD) || (state == WR)) && !bus.resp_i;

  // Saturating event counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_count_o     <= '0;
      wr_count_o     <= '0;
      stall_cycles_o <= '0;
    end else begin
      if (rd_finish && rd_count_o != 32'hFFFF_FFFF) begin
        rd_count_o <= rd_count_o + 32'd1;
      end
      if (wr_finish && wr_count_o != 32'hFFFF_FFFF) begin
        wr_count_o <= wr_count_o + 32'd1;
      end
      if (stall_now && stall_cycles_o != 32'hFFFF_FFFF) begin
        stall_cycles_o <= stall_cycles_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cacheline_adapter.sv
// tb_cacheline_adapter
// Directed bench for cacheline_adapter. A transaction-level model tracks
// what the cache and memory ports must show each cycle; a compare process
// checks the DUT against it on every falling edge, and the directed
// sequences add hand-computed literal checks.
// Also exercises the counters when CACHELINE_ADAPTER_PERF_EN is defined.
module tb_cacheline_adapter;
  import cacheline_adapter_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  cacheline_adapter_if bus ();

`ifdef CACHELINE_ADAPTER_PERF_EN
  logic [31:0] rd_count, wr_count, stall_cycles;
`endif

  cacheline_adapter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef CACHELINE_ADAPTER_PERF_EN
    ,
    .rd_count_o     (rd_count),
    .wr_count_o     (wr_count),
    .stall_cycles_o (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_output(input string name, input logic [255:0] actual,
                              input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Inputs change 1 time unit after the rising edge so the DUT and the
  // model both sample stable values on the next edge.
  task automatic apply_stimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                input cacheline_t line, input burst_t beat, input logic ack);
    @(posedge clk);
    #1;
    bus.read_i    = rd;
    bus.write_i   = wr;
    bus.address_i = addr;
    bus.line_i    = line;
    bus.burst_i   = beat;
    bus.resp_i    = ack;
  endtask

  // Transaction model: phase 0 idle, 1 reading, 2 writing, 3 line done.
  // beats = beats acknowledged so far in the current burst.
  int          phase = 0;
  int          beats = 0;
  burst_t      m_line [4];
  burst_t      m_wbuf [4];
  logic [31:0] m_addr = '0;
  int          m_rd_done = 0;
  int          m_wr_done = 0;
  int          m_stall = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      phase     = 0;
      beats     = 0;
      m_addr    = '0;
      m_rd_done = 0;
      m_wr_done = 0;
      m_stall   = 0;
      for (int i = 0; i < 4; i++) begin
        m_line[i] = '0;
        m_wbuf[i] = '0;
      end
    end else begin
      case (phase)
        0: begin
          if (bus.read_i) begin
            m_addr = {bus.address_i[31:5], 5'b0};
            phase  = 1;
            beats  = 0;
          end else if (bus.write_i) begin
            m_addr = {bus.address_i[31:5], 5'b0};
            for (int i = 0; i < 4; i++) m_wbuf[i] = bus.line_i[i*64 +: 64];
            phase = 2;
            beats = 0;
          end
        end
        1: begin
          if (bus.resp_i) begin
            m_line[beats] = bus.burst_i;
            beats++;
            if (beats == 4) begin
              phase = 3;
              m_rd_done++;
            end
          end else begin
            m_stall++;
          end
        end
        2: begin
          if (bus.resp_i) begin
            beats++;
            if (beats == 4) begin
              phase = 3;
              m_wr_done++;
            end
          end else begin
            m_stall++;
          end
        end
        default: phase = 0;
      endcase
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    check_output("read_o", 256'(bus.read_o), 256'(phase == 1));
    check_output("write_o", 256'(bus.write_o), 256'(phase == 2));
    check_output("resp_o", 256'(bus.resp_o), 256'(phase == 3));
    check_output("address_o", 256'(bus.address_o), 256'(m_addr));
    check_output("line_o", bus.line_o, {m_line[3], m_line[2], m_line[1], m_line[0]});
    if (phase == 2 && beats < 4) begin
      check_output("burst_o", 256'(bus.burst_o), 256'(m_wbuf[beats]));
    end
  end

  burst_t wr_expect [8] = '{64'hD0, 64'hD0, 64'hD1, 64'hD2, 64'hD2, 64'hD3, 64'hD3, 64'hD3};
  logic   wr_ack    [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    cacheline_t wline;
    burst_t     beat;

    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.address_i = '0;
    bus.line_i    = '0;
    bus.burst_i   = '0;
    bus.resp_i    = 1'b0;

    // Reset: all outputs low.
    #1 reset = 1'b1;
    @(negedge clk);
    check_output("rst_read_o", 256'(bus.read_o), 256'(0));
    check_output("rst_write_o", 256'(bus.write_o), 256'(0));
    check_output("rst_resp_o", 256'(bus.resp_o), 256'(0));
    check_output("rst_line_o", bus.line_o, '0);
    check_output("rst_burst_o", 256'(bus.burst_o), 256'(0));
    check_output("rst_address_o", 256'(bus.address_o), 256'(0));
    @(posedge clk);
    #1 reset = 1'b0;

    // Zero-wait read.
    $display("[TB] zero-wait read");
    apply_stimulus(1'b1, 1'b0, 32'h0000_1234, '0, '0, 1'b0);
    for (int b = 0; b < 4; b++) begin
      beat = 64'hA0 + 64'(b);
      apply_stimulus(1'b0, 1'b0, '0, '0, beat, 1'b1);
      @(negedge clk);
      check_output("rd_read_high", 256'(bus.read_o), 256'(1));
      check_output("rd_address", 256'(bus.address_o), 256'(32'h0000_1220));
    end
    apply_stimulus(1'b0, 1'b0, '0, '0, '0, 1'b0);
    @(negedge clk);
    check_output("rd_resp_cycle5", 256'(bus.resp_o), 256'(1));
    check_output("rd_read_low", 256'(bus.read_o), 256'(0));
    check_output("rd_line", bus.line_o, {64'hA3, 64'hA2, 64'hA1, 64'hA0});
    apply_stimulus(1'b0, 1'b0, '0, '0, '0, 1'b0);
    @(negedge clk);
    check_output("rd_resp_one_cycle", 256'(bus.resp_o), 256'(0));

    // Write with wait states: acks in cycles 2,3,5,8.
    $display("[TB] write with waits");
    wline = {64'hD3, 64'hD2, 64'hD1, 64'hD0};
    apply_stimulus(1'b0, 1'b1, 32'h0000_4000, wline, '0, 1'b0);
    for (int c = 0; c < 8; c++) begin
      apply_stimulus(1'b0, 1'b0, '0, '0, '0, wr_ack[c]);
      @(negedge clk);
      check_output("wr_write_high", 256'(bus.write_o), 256'(1));
      check_output("wr_burst_seq", 256'(bus.burst_o), 256'(wr_expect[c]));
    end
    apply_stimulus(1'b0, 1'b0, '0, '0, '0, 1'b0);
    @(negedge clk);
    check_output("wr_resp", 256'(bus.resp_o), 256'(1));
    check_output("wr_write_low", 256'(bus.write_o), 256'(0));
    apply_stimulus(1'b0, 1'b0, '0, '0, '0, 1'b0);
    @(negedge clk);
    check_output("wr_write_stays_low", 256'(bus.write_o), 256'(0));

    // Simultaneous read and write: read wins.
    $display("[TB] simultaneous read and write");
    apply_stimulus(1'b1, 1'b1, 32'h0000_8008, {4{64'h5555}}, '0, 1'b0);
    for (int b = 0; b < 4; b++) begin
      beat = 64'hB0 + 64'(b);
      apply_stimulus(1'b0, 1'b0, '0, '0, beat, 1'b1);
      @(negedge clk);
      check_output("both_write_low", 256'(bus.write_o), 256'(0));
    end
    apply_stimulus(1'b0, 1'b0, '0, '0, '0, 1'b0);
    @(negedge clk);
    check_output("both_resp", 256'(bus.resp_o), 256'(1));
    check_output("both_line", bus.line_o, {64'hB3, 64'hB2, 64'hB1, 64'hB0});
    check_output("both_address", 256'(bus.address_o), 256'(32'h0000_8000));

    // Reset after beat 2 of a read, then a fresh read.
    $display("[TB] reset mid-read");
    apply_stimulus(1'b1, 1'b0, 32'h0000_C010, '0, '0, 1'b0);
    apply_stimulus(1'b0, 1'b0, '0, '0, 64'hE0, 1'b1);
    apply_stimulus(1'b0, 1'b0, '0, '0, 64'hE1, 1'b1);
    @(posedge clk);
    #1;
    reset       = 1'b1;
    bus.resp_i  = 1'b0;
    bus.burst_i = '0;
    @(negedge clk);
    check_output("abort_read_o", 256'(bus.read_o), 256'(0));
    check_output("abort_resp_o", 256'(bus.resp_o), 256'(0));
`ifdef CACHELINE_ADAPTER_PERF_EN
    check_output("perf_rst_rd", 256'(rd_count), 256'(0));
    check_output("perf_rst_wr", 256'(wr_count), 256'(0));
    check_output("perf_rst_stall", 256'(stall_cycles), 256'(0));
`endif
    @(posedge clk);
    #1 reset = 1'b0;
    apply_stimulus(1'b0, 1'b0, '0, '0, '0, 1'b0);
    @(negedge clk);
    check_output("abort_idle_resp", 256'(bus.resp_o), 256'(0));
    apply_stimulus(1'b1, 1'b0, 32'h0000_2040, '0, '0, 1'b0);
    for (int b = 0; b < 4; b++) begin
      beat = 64'hF0 + 64'(b);
      apply_stimulus(1'b0, 1'b0, '0, '0, beat, 1'b1);
    end
    apply_stimulus(1'b0, 1'b0, '0, '0, '0, 1'b0);
    @(negedge clk);
    check_output("post_rst_resp", 256'(bus.resp_o), 256'(1));
    check_output("post_rst_line", bus.line_o, {64'hF3, 64'hF2, 64'hF1, 64'hF0});

    // Back-to-back: read, then write raised the cycle after resp_o.
    $display("[TB] back-to-back read then write");
    apply_stimulus(1'b1, 1'b0, 32'h0001_0000, '0, '0, 1'b0);
    for (int b = 0; b < 4; b++) begin
      beat = 64'hC0 + 64'(b);
      apply_stimulus(1'b0, 1'b0, '0, '0, beat, 1'b1);
    end
    apply_stimulus(1'b0, 1'b0, '0, '0, '0, 1'b0);
    @(negedge clk);
    check_output("b2b_rd_resp", 256'(bus.resp_o), 256'(1));
    wline = {64'h93, 64'h92, 64'h91, 64'h90};
    apply_stimulus(1'b0, 1'b1, 32'h0002_003F, wline, '0, 1'b0);
    for (int b = 0; b < 4; b++) begin
      apply_stimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);
      @(negedge clk);
      check_output("b2b_write_o", 256'(bus.write_o), 256'(1));
      check_output("b2b_burst", 256'(bus.burst_o), 256'(64'h90 + 64'(b)));
    end
    apply_stimulus(1'b0, 1'b0, '0, '0, '0, 1'b0);
    @(negedge clk);
    check_output("b2b_wr_resp", 256'(bus.resp_o), 256'(1));
    check_output("b2b_address", 256'(bus.address_o), 256'(32'h0002_0020));
    check_output("b2b_line_held", bus.line_o, {64'hC3, 64'hC2, 64'hC1, 64'hC0});

`ifdef CACHELINE_ADAPTER_PERF_EN
    @(negedge clk);
    check_output("perf_rd_model", 256'(rd_count), 256'(m_rd_done));
    check_output("perf_wr_model", 256'(wr_count), 256'(m_wr_done));
    check_output("perf_stall_model", 256'(stall_cycles), 256'(m_stall));
    check_output("perf_rd_lit", 256'(rd_count), 256'(2));
    check_output("perf_wr_lit", 256'(wr_count), 256'(1));
    check_output("perf_stall_lit", 256'(stall_cycles), 256'(0));
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cacheline_adapter.md
Name: cacheline_adapter

Overview:
Sits directly downstream of the L1 cache, between its 256-bit line port (pmem_*) and the 64-bit burst physical memory. Converts one line read into a 4-beat burst read that is assembled into a full line, and one line write into a 4-beat burst write. A single line response is returned upstream once the whole burst has finished. One transaction is in flight at a time.

Parameters:
s_line, 256, line width in bits (matches cache s_line)
s_burst, 64, burst beat width in bits
s_offset, 5, line offset bits zeroed in the outgoing address
num_beats, s_line/s_burst (4), beats per line; derived, not overridable

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
line_i  input  256  line write data from cache (pmem_wdata)
line_o  output  256  assembled line read data to cache (pmem_rdata)
address_i  input  32  line address from cache (pmem_address)
read_i  input  1  line read request (pmem_read)
write_i  input  1  line write request (pmem_write)
resp_o  output  1  line done, 1-cycle pulse (pmem_resp)
burst_i  input  64  read beat data from memory
burst_o  output  64  write beat data to memory
address_o  output  32  burst address, {address_i[31:5], 5'b0}
read_o  output  1  burst read request
write_o  output  1  burst write request
resp_i  input  1  memory beat acknowledge, one per beat

Behaviour:
- Reset (async, active-high): state IDLE, beat count 0. All outputs are 0: line_o, burst_o, address_o, read_o, write_o, resp_o.
- Reset asserted mid-burst aborts the transaction immediately. No resp_o is issued.
- All outputs are registered.
- States: IDLE, RD, RD_DONE, WR, WR_DONE.
- IDLE, read_i=1: latch the aligned address into address_o, zero the count, go to RD. read_o goes high in the next cycle.
- IDLE, write_i=1: latch line_i into a write buffer, latch the address, go to WR. write_o goes high and burst_o = buffer[63:0] in the next cycle.
- IDLE, read_i and write_i both high: read wins; write_i is ignored.
- IDLE: resp_i is ignored.
- RD: read_o is held high. On each cycle with resp_i=1:
  - line_o[count*64 +: 64] <= burst_i;
  - count increments.
  - On the 4th beat: read_o <= 0, go to RD_DONE.
- RD: a cycle with resp_i=0 is a wait state; nothing changes.
- RD_DONE: resp_o=1 for exactly one cycle, with line_o valid in that same cycle, then go to IDLE.
- WR: write_o is held high and burst_o = buffer[count*64 +: 64]. Each resp_i advances count, and burst_o updates on the following cycle. On the 4th beat: write_o <= 0, go to WR_DONE.
- WR_DONE: resp_o=1 for one cycle, then go to IDLE.
- Beat order is fixed at 0,1,2,3 (low beat first). There is no critical-word-first ordering.
- Count is 2 bits and wraps 3->0 only on the transition to DONE.
- address_o and the write buffer are stable for the whole burst. Changes on address_i, line_i, read_i and write_i during a burst are ignored.
- line_o holds its last value until the next read completes.
- Latency, with request sampled in cycle 0: read_o/write_o high from cycle 1. With zero-wait memory, beats land in cycles 1..4 and resp_o is in cycle 5.
- Minimum latency: 5 cycles request-to-resp.
- Back-to-back: a new request is accepted in the cycle after resp_o.

Optional Feature:
- Macro: CACHELINE_ADAPTER_PERF_EN.
- Defined:
  - Adds outputs rd_count_o[31:0] and wr_count_o[31:0].
  - Each counter increments on entry to RD_DONE or WR_DONE respectively.
  - Counters saturate at 32'hFFFFFFFF and clear on reset.
  - Adds stall_cycles_o[31:0], counting RD/WR cycles with resp_i=0, same saturation and reset rules.
- Undefined: these ports and counters do not exist, and there is no logic overhead.

Decomposition:
- rv32i_types package gains:
  - typedef cacheline_t (logic [255:0]);
  - typedef burst_t (logic [63:0]);
  - enum adapter_state_t {IDLE, RD, RD_DONE, WR, WR_DONE};
  - localparam BURST_BEATS = 4.
- One sub-module is natural: adapter_beat_counter, a 2-bit counter with clear, advance and a last-beat flag.
- The datapath (line assembly/select) stays in cacheline_adapter.

Test Plan:
- Read, zero-wait: address_i=32'h0000_1234, read_i=1; burst_i = 64'hA0,A1,A2,A3 with resp_i=1 for 4 cycles -> address_o=32'h0000_1220; read_o high for 4 cycles; resp_o in cycle 5; line_o={A3,A2,A1,A0}.
- Write with waits: line_i={64'hD3,64'hD2,64'hD1,64'hD0}, write_i=1; resp_i on cycles 2,3,5,8 -> burst_o sequence D0,D1,D2,D3, each held until acked; resp_o one cycle after the cycle-8 ack; write_o low thereafter.
- Simultaneous read_i=1 and write_i=1 in IDLE -> read burst only; write_o stays 0 throughout.
- Reset after beat 2 of a read -> read_o=0, resp_o never pulses, state IDLE. A new read then completes normally in 5 cycles.
- Back-to-back read then write, requests re-raised the cycle after resp_o -> second burst's write_o rises 1 cycle after acceptance; no beat lost or duplicated.
- PERF_EN build: 3 reads, 2 writes, 4 wait cycles -> rd_count_o=3, wr_count_o=2, stall_cycles_o=4; all clear to 0 on reset.
